// File: rtl/score_board.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : score_board (with score_board_pkg)                           |
// | Description : Dual-issue register scoreboard. Tracks which pipeline stage  |
// |               (execute/memory/commit) holds an in-flight write to each     |
// |               register and from which lane, and reports the forwarding     |
// |               source and load-use hazards for each operand read port.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package score_board_pkg;
   // Lane index width for a two-lane machine.
   localparam int LINE_W = 1;

   typedef struct packed {
      logic [2:0]        position;  // bit2 execute, bit1 memory, bit0 commit
      logic [LINE_W-1:0] line;      // lane of the youngest matching write
   } SCORE_BOARD_DATA;
endpackage

module score_board #(
   parameter int REG_NUM     = 32,
   parameter int ISSUE_WIDTH = 2,
   parameter int READ_PORTS  = 4,
   parameter int ADDR_W      = $clog2(REG_NUM)
) (
   input  logic                                           clk,
   input  logic                                           resetn,
   input  logic [ISSUE_WIDTH-1:0]                         issue_valid,
   input  logic [ISSUE_WIDTH-1:0]                         issue_we,
   input  logic [ISSUE_WIDTH-1:0]                         issue_load,
   input  logic [ISSUE_WIDTH-1:0][ADDR_W-1:0]             issue_dest,
   input  logic                                           pipe_stall,
   input  logic                                           flush_exec,
   input  logic [READ_PORTS-1:0][ADDR_W-1:0]              read_addr,
   output score_board_pkg::SCORE_BOARD_DATA [READ_PORTS-1:0] score_board_data,
   output logic [READ_PORTS-1:0]                          read_hit,
   output logic                                           load_use
);

   localparam int c_line_w = score_board_pkg::LINE_W;

   // Per-register tracking state; r0 is never set because its issue match is masked.
   logic [2:0]               r_pos [REG_NUM];
   logic [2:0][c_line_w-1:0] r_ln  [REG_NUM];
   logic                     r_ld  [REG_NUM];

   for (genvar r = 0; r < REG_NUM; r++) begin : g_reg
      logic [2:0]               w_pos_nxt;
      logic [2:0][c_line_w-1:0] w_ln_nxt;
      logic                     w_ld_nxt;

      // Next state: shift one stage on advance, then apply flush or new issue.
      always_comb begin
         w_pos_nxt = r_pos[r];
         w_ln_nxt  = r_ln[r];
         w_ld_nxt  = r_ld[r];
         if (!pipe_stall) begin
            w_pos_nxt = {1'b0, r_pos[r][2:1]};
            w_ln_nxt  = {{c_line_w{1'b0}}, r_ln[r][2:1]};
            w_ld_nxt  = 1'b0;
            if (flush_exec) begin
               // The write that was in execute would now sit in memory; kill it.
               w_pos_nxt[1] = 1'b0;
               w_ln_nxt[1]  = '0;
            end else begin
               // Ascending lane order lets the higher lane win a same-dest pair.
               for (int i = 0; i < ISSUE_WIDTH; i++) begin
                  if (issue_valid[i] && issue_we[i] && (r != 0) &&
                      (issue_dest[i] == ADDR_W'(r))) begin
                     w_pos_nxt[2] = 1'b1;
                     w_ln_nxt[2]  = c_line_w'(i);
                     w_ld_nxt     = issue_load[i];
                  end
               end
            end
         end else if (flush_exec) begin
            // Stalled flush: drop the execute write in place without shifting.
            w_pos_nxt[2] = 1'b0;
            w_ld_nxt     = 1'b0;
         end
      end

      // State register with synchronous active-low clear.
      always_ff @(posedge clk) begin
         if (!resetn) begin
            r_pos[r] <= '0;
            r_ln[r]  <= '0;
            r_ld[r]  <= 1'b0;
         end else begin
            r_pos[r] <= w_pos_nxt;
            r_ln[r]  <= w_ln_nxt;
            r_ld[r]  <= w_ld_nxt;
         end
      end
   end

   logic [READ_PORTS-1:0] w_lu;

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      logic [2:0]          w_pos;
      logic [c_line_w-1:0] w_line;

      // Lookup: position and lane of the youngest write, execute > memory > commit.
      always_comb begin
         w_pos   = '0;
         w_line  = '0;
         w_lu[p] = 1'b0;
         if (read_addr[p] != '0) begin
            w_pos = r_pos[read_addr[p]];
            if (w_pos[2]) begin
               w_line = r_ln[read_addr[p]][2];
            end else if (w_pos[1]) begin
               w_line = r_ln[read_addr[p]][1];
            end else if (w_pos[0]) begin
               w_line = r_ln[read_addr[p]][0];
            end
            w_lu[p] = w_pos[2] & r_ld[read_addr[p]];
         end
      end

      assign score_board_data[p].position = w_pos;
      assign score_board_data[p].line     = w_line;
      assign read_hit[p]                  = |w_pos;
   end

   assign load_use = |w_lu;

endmodule
`default_nettype wire

// File: tb/tb_score_board.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_score_board                                               |
// | Description : Self-checking bench for score_board: directed scenarios plus |
// |               randomized traffic against a pipeline-occupancy model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_score_board;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic [1:0]           issue_valid, issue_we, issue_load;
   logic [1:0][4:0]      issue_dest;
   logic                 pipe_stall, flush_exec;
   logic [3:0][4:0]      read_addr;
   score_board_pkg::SCORE_BOARD_DATA [3:0] score_board_data;
   logic [3:0]           read_hit;
   logic                 load_use;

   int n_cmp = 0;
   int n_err = 0;

   // Model: which instructions occupy each stage (0 exec, 1 mem, 2 commit) per lane.
   bit       m_v [3][2];
   bit [4:0] m_d [3][2];
   bit       m_l [3][2];

   score_board u_dut (
      .clk              (clk),
      .resetn           (resetn),
      .issue_valid      (issue_valid),
      .issue_we         (issue_we),
      .issue_load       (issue_load),
      .issue_dest       (issue_dest),
      .pipe_stall       (pipe_stall),
      .flush_exec       (flush_exec),
      .read_addr        (read_addr),
      .score_board_data (score_board_data),
      .read_hit         (read_hit),
      .load_use         (load_use)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic idle_inputs();
      issue_valid = '0;
      issue_we    = '0;
      issue_load  = '0;
      issue_dest  = '0;
      pipe_stall  = 1'b0;
      flush_exec  = 1'b0;
   endtask

   task automatic model_step();
      if (!resetn) begin
         for (int s = 0; s < 3; s++)
            for (int l = 0; l < 2; l++) m_v[s][l] = 0;
      end else if (!pipe_stall) begin
         for (int l = 0; l < 2; l++) begin
            m_v[2][l] = m_v[1][l]; m_d[2][l] = m_d[1][l]; m_l[2][l] = m_l[1][l];
            m_v[1][l] = flush_exec ? 1'b0 : m_v[0][l];
            m_d[1][l] = m_d[0][l]; m_l[1][l] = m_l[0][l];
            m_v[0][l] = !flush_exec && issue_valid[l] && issue_we[l] && (issue_dest[l] != 0);
            m_d[0][l] = issue_dest[l]; m_l[0][l] = issue_load[l];
         end
      end else if (flush_exec) begin
         for (int l = 0; l < 2; l++) m_v[0][l] = 0;
      end
   endtask

   // Expected lookup for one register address from the model.
   task automatic model_lookup(input bit [4:0] a, output bit [2:0] pos, output bit ln, output bit lu);
      bit found;
      pos = 0; ln = 0; lu = 0; found = 0;
      for (int s = 0; s < 3; s++) begin
         for (int l = 0; l < 2; l++) begin
            if (a != 0 && m_v[s][l] && m_d[s][l] == a) begin
               pos[2-s] = 1'b1;
               if (!found) ln = l[0];
               if (s == 0) lu = m_l[s][l];
            end
         end
         if (pos[2-s]) found = 1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drain();
      idle_inputs();
      read_addr = '0;
      repeat (4) cycle();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle_inputs();
      read_addr = '0;
      repeat (2) cycle();
      resetn = 1'b1;
      read_addr = {5'd31, 5'd17, 5'd5, 5'd1};
      cycle();
      for (int p = 0; p < 4; p++) begin
         n_cmp++;
         if (score_board_data[p].position !== 3'b000 || score_board_data[p].line !== 1'b0 || read_hit[p] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_port%0d pos=%b line=%b hit=%b want 000/0/0", p,
                     score_board_data[p].position, score_board_data[p].line, read_hit[p]);
         end
      end
      n_cmp++;
      if (load_use !== 1'b0) begin
         n_err++;
         $display("FAIL reset_load_use got %b want 0", load_use);
      end
   endtask

   task automatic test_shift();
      logic [2:0] exp_pos [4];
      exp_pos = '{3'b100, 3'b010, 3'b001, 3'b000};
      idle_inputs();
      issue_valid = 2'b10; issue_we = 2'b10; issue_dest[1] = 5'd5;
      read_addr = '0; read_addr[0] = 5'd5;
      cycle();
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (score_board_data[0].position !== exp_pos[k] ||
             (k < 3 && score_board_data[0].line !== 1'b1) || read_hit[0] !== (k < 3)) begin
            n_err++;
            $display("FAIL shift_r5_c%0d pos=%b line=%b hit=%b want %b/1/%0d", k,
                     score_board_data[0].position, score_board_data[0].line, read_hit[0], exp_pos[k], k < 3);
         end
         cycle();
      end
      drain();
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      read_addr = '0; read_addr[2] = 5'd7;
      issue_valid = 2'b01; issue_we = 2'b01; issue_dest[0] = 5'd7;
      cycle();
      idle_inputs();
      issue_valid = 2'b10; issue_we = 2'b10; issue_dest[1] = 5'd7;
      cycle();
      idle_inputs();
      n_cmp++;
      if (score_board_data[2].position !== 3'b110 || score_board_data[2].line !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_t2 pos=%b line=%b want 110/1", score_board_data[2].position, score_board_data[2].line);
      end
      cycle();
      n_cmp++;
      if (score_board_data[2].position !== 3'b011 || score_board_data[2].line !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_t3 pos=%b line=%b want 011/1", score_board_data[2].position, score_board_data[2].line);
      end
      drain();
   endtask

   task automatic test_load_use();
      idle_inputs();
      read_addr = '0; read_addr[1] = 5'd3;
      issue_valid = 2'b01; issue_we = 2'b01; issue_load = 2'b01; issue_dest[0] = 5'd3;
      cycle();
      idle_inputs();
      n_cmp++;
      if (load_use !== 1'b1 || score_board_data[1].position !== 3'b100) begin
         n_err++;
         $display("FAIL load_use_exec lu=%b pos=%b want 1/100", load_use, score_board_data[1].position);
      end
      cycle();
      n_cmp++;
      if (load_use !== 1'b0 || score_board_data[1].position !== 3'b010) begin
         n_err++;
         $display("FAIL load_use_mem lu=%b pos=%b want 0/010", load_use, score_board_data[1].position);
      end
      drain();
   endtask

   task automatic test_stall_flush();
      idle_inputs();
      read_addr = '0; read_addr[0] = 5'd11; read_addr[3] = 5'd12;
      issue_valid = 2'b01; issue_we = 2'b01; issue_dest[0] = 5'd11;
      cycle();
      idle_inputs();
      pipe_stall = 1'b1;
      issue_valid = 2'b10; issue_we = 2'b10; issue_dest[1] = 5'd12;
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_cmp++;
         if (score_board_data[0].position !== 3'b100 || score_board_data[3].position !== 3'b000) begin
            n_err++;
            $display("FAIL stall_c%0d r11=%b r12=%b want 100/000", k,
                     score_board_data[0].position, score_board_data[3].position);
         end
      end
      issue_valid = '0; issue_we = '0;
      flush_exec = 1'b1;
      cycle();
      n_cmp++;
      if (score_board_data[0].position !== 3'b000 || read_hit[0] !== 1'b0) begin
         n_err++;
         $display("FAIL stall_flush r11 pos=%b hit=%b want 000/0", score_board_data[0].position, read_hit[0]);
      end
      drain();
   endtask

   task automatic test_same_dest_and_reset();
      idle_inputs();
      read_addr = '0; read_addr[0] = 5'd9; read_addr[1] = 5'd4;
      issue_valid = 2'b11; issue_we = 2'b11; issue_load = 2'b01;
      issue_dest[0] = 5'd9; issue_dest[1] = 5'd9;
      cycle();
      idle_inputs();
      n_cmp++;
      if (score_board_data[0].position !== 3'b100 || score_board_data[0].line !== 1'b1 || load_use !== 1'b0) begin
         n_err++;
         $display("FAIL same_dest pos=%b line=%b lu=%b want 100/1/0",
                  score_board_data[0].position, score_board_data[0].line, load_use);
      end
      issue_valid = 2'b01; issue_we = 2'b01; issue_dest[0] = 5'd4;
      cycle();
      resetn = 1'b0;
      issue_valid = 2'b10; issue_we = 2'b10; issue_dest[1] = 5'd4;
      cycle();
      resetn = 1'b1;
      idle_inputs();
      for (int p = 0; p < 2; p++) begin
         n_cmp++;
         if (score_board_data[p].position !== 3'b000 || score_board_data[p].line !== 1'b0 || read_hit[p] !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_reset_port%0d pos=%b line=%b hit=%b want 000/0/0", p,
                     score_board_data[p].position, score_board_data[p].line, read_hit[p]);
         end
      end
      n_cmp++;
      if (load_use !== 1'b0) begin
         n_err++;
         $display("FAIL midflight_reset_lu got %b want 0", load_use);
      end
      drain();
   endtask

   task automatic test_random();
      bit [2:0] e_pos;
      bit       e_ln, e_lu, any_lu;
      for (int n = 0; n < 400; n++) begin
         resetn      = ($urandom_range(0, 49) != 0);
         issue_valid = 2'($urandom);
         issue_we    = 2'($urandom);
         issue_load  = 2'($urandom);
         issue_dest[0] = 5'($urandom_range(0, 7));
         issue_dest[1] = ($urandom_range(0, 3) == 0) ? issue_dest[0] : 5'($urandom_range(0, 7));
         pipe_stall  = ($urandom_range(0, 4) == 0);
         flush_exec  = ($urandom_range(0, 9) == 0);
         for (int p = 0; p < 4; p++) read_addr[p] = 5'($urandom_range(0, 7));
         cycle();
         any_lu = 0;
         for (int p = 0; p < 4; p++) begin
            model_lookup(read_addr[p], e_pos, e_ln, e_lu);
            any_lu |= e_lu;
            n_cmp++;
            if (score_board_data[p].position !== e_pos || score_board_data[p].line !== e_ln ||
                read_hit[p] !== (e_pos != 0)) begin
               n_err++;
               $display("FAIL rand%0d_port%0d addr=%0d pos=%b line=%b hit=%b want %b/%b/%b", n, p, read_addr[p],
                        score_board_data[p].position, score_board_data[p].line, read_hit[p], e_pos, e_ln, e_pos != 0);
            end
         end
         n_cmp++;
         if (load_use !== any_lu) begin
            n_err++;
            $display("FAIL rand%0d_load_use got %b want %b", n, load_use, any_lu);
         end
      end
      resetn = 1'b1;
      drain();
   endtask

   initial begin
      resetn = 1'b0;
      idle_inputs();
      read_addr = '0;
      test_reset();
      test_shift();
      test_back_to_back();
      test_load_use();
      test_stall_flush();
      test_same_dest_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
